// File: rtl/ysyx_040750_clint_arb.sv
// rtl/ysyx_040750_clint_arb.sv - two-master arbiter for the CLINT slave port, independent read/write FSMs
// Define YSYX_040750_CLINT_ARB_RR_EN for round-robin tie-breaking; otherwise m0 has fixed priority.
module ysyx_040750_clint_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_m0_arvalid,
  output logic                  O_m0_arready,
  input  logic [ADDR_W-1:0]     I_m0_araddr,
  output logic                  O_m0_rvalid,
  input  logic                  I_m0_rready,
  output logic [DATA_W-1:0]     O_m0_rdata,
  input  logic                  I_m0_awvalid,
  output logic                  O_m0_awready,
  input  logic [ADDR_W-1:0]     I_m0_awaddr,
  input  logic                  I_m0_wvalid,
  output logic                  O_m0_wready,
  input  logic [DATA_W-1:0]     I_m0_wdata,
  input  logic [DATA_W/8-1:0]   I_m0_wstrb,
  output logic                  O_m0_bvalid,
  input  logic                  I_m0_bready,
  input  logic                  I_m1_arvalid,
  output logic                  O_m1_arready,
  input  logic [ADDR_W-1:0]     I_m1_araddr,
  output logic                  O_m1_rvalid,
  input  logic                  I_m1_rready,
  output logic [DATA_W-1:0]     O_m1_rdata,
  input  logic                  I_m1_awvalid,
  output logic                  O_m1_awready,
  input  logic [ADDR_W-1:0]     I_m1_awaddr,
  input  logic                  I_m1_wvalid,
  output logic                  O_m1_wready,
  input  logic [DATA_W-1:0]     I_m1_wdata,
  input  logic [DATA_W/8-1:0]   I_m1_wstrb,
  output logic                  O_m1_bvalid,
  input  logic                  I_m1_bready,
  output logic                  O_s_arvalid,
  input  logic                  I_s_arready,
  output logic [ADDR_W-1:0]     O_s_araddr,
  input  logic                  I_s_rvalid,
  output logic                  O_s_rready,
  input  logic [DATA_W-1:0]     I_s_rdata,
  output logic                  O_s_awvalid,
  input  logic                  I_s_awready,
  output logic [ADDR_W-1:0]     O_s_awaddr,
  output logic                  O_s_wvalid,
  input  logic                  I_s_wready,
  output logic [DATA_W-1:0]     O_s_wdata,
  output logic [DATA_W/8-1:0]   O_s_wstrb,
  input  logic                  I_s_bvalid,
  output logic                  O_s_bready,
  output logic                  O_rd_busy,
  output logic                  O_wr_busy
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t rstate, rstate_nxt;
  wr_state_t wstate, wstate_nxt;
  logic      rgnt, rgnt_nxt, wgnt, wgnt_nxt;
  logic      r_pick, w_pick;

`ifdef YSYX_040750_CLINT_ARB_RR_EN
  // Pointers remember the master granted last; on a tie the other one wins.
  logic rptr, wptr;

  assign r_pick = (I_m0_arvalid & I_m1_arvalid) ? ~rptr : I_m1_arvalid;
  assign w_pick = (I_m0_awvalid & I_m1_awvalid) ? ~wptr : I_m1_awvalid;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rptr <= 1'b0;
      wptr <= 1'b0;
    end else begin
      if (rstate == R_IDLE && (I_m0_arvalid | I_m1_arvalid)) rptr <= r_pick;
      if (wstate == W_IDLE && (I_m0_awvalid | I_m1_awvalid)) wptr <= w_pick;
    end
  end
`else
  assign r_pick = ~I_m0_arvalid;
  assign w_pick = ~I_m0_awvalid;
`endif

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rstate <= R_IDLE;
      wstate <= W_IDLE;
      rgnt   <= 1'b0;
      wgnt   <= 1'b0;
    end else begin
      rstate <= rstate_nxt;
      wstate <= wstate_nxt;
      rgnt   <= rgnt_nxt;
      wgnt   <= wgnt_nxt;
    end
  end

  assign O_rd_busy = (rstate != R_IDLE);
  assign O_wr_busy = (wstate != W_IDLE);

  // Read path: every output defaults to 0 so idle and non-granted sides stay silent.
  always_comb begin
    rstate_nxt   = rstate;
    rgnt_nxt     = rgnt;
    O_s_arvalid  = 1'b0;
    O_s_araddr   = '0;
    O_s_rready   = 1'b0;
    O_m0_arready = 1'b0;
    O_m1_arready = 1'b0;
    O_m0_rvalid  = 1'b0;
    O_m1_rvalid  = 1'b0;
    O_m0_rdata   = '0;
    O_m1_rdata   = '0;
    case (rstate)
      R_IDLE: begin
        if (I_m0_arvalid | I_m1_arvalid) begin
          rgnt_nxt   = r_pick;
          rstate_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        O_s_arvalid  = rgnt ? I_m1_arvalid : I_m0_arvalid;
        O_s_araddr   = rgnt ? I_m1_araddr : I_m0_araddr;
        O_m0_arready = ~rgnt & I_s_arready;
        O_m1_arready = rgnt & I_s_arready;
        if (O_s_arvalid & I_s_arready) rstate_nxt = R_DATA;
      end
      R_DATA: begin
        O_s_rready  = rgnt ? I_m1_rready : I_m0_rready;
        O_m0_rvalid = ~rgnt & I_s_rvalid;
        O_m1_rvalid = rgnt & I_s_rvalid;
        O_m0_rdata  = rgnt ? '0 : I_s_rdata;
        O_m1_rdata  = rgnt ? I_s_rdata : '0;
        if (I_s_rvalid & O_s_rready) rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // Write path: b is routed during W_DATA too, since the slave answers in the w handshake cycle.
  always_comb begin
    wstate_nxt   = wstate;
    wgnt_nxt     = wgnt;
    O_s_awvalid  = 1'b0;
    O_s_awaddr   = '0;
    O_s_wvalid   = 1'b0;
    O_s_wdata    = '0;
    O_s_wstrb    = '0;
    O_s_bready   = 1'b0;
    O_m0_awready = 1'b0;
    O_m1_awready = 1'b0;
    O_m0_wready  = 1'b0;
    O_m1_wready  = 1'b0;
    O_m0_bvalid  = 1'b0;
    O_m1_bvalid  = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (I_m0_awvalid | I_m1_awvalid) begin
          wgnt_nxt   = w_pick;
          wstate_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        O_s_awvalid  = wgnt ? I_m1_awvalid : I_m0_awvalid;
        O_s_awaddr   = wgnt ? I_m1_awaddr : I_m0_awaddr;
        O_m0_awready = ~wgnt & I_s_awready;
        O_m1_awready = wgnt & I_s_awready;
        if (O_s_awvalid & I_s_awready) wstate_nxt = W_DATA;
      end
      W_DATA: begin
        O_s_wvalid  = wgnt ? I_m1_wvalid : I_m0_wvalid;
        O_s_wdata   = wgnt ? I_m1_wdata : I_m0_wdata;
        O_s_wstrb   = wgnt ? I_m1_wstrb : I_m0_wstrb;
        O_m0_wready = ~wgnt & I_s_wready;
        O_m1_wready = wgnt & I_s_wready;
        O_s_bready  = wgnt ? I_m1_bready : I_m0_bready;
        O_m0_bvalid = ~wgnt & I_s_bvalid;
        O_m1_bvalid = wgnt & I_s_bvalid;
        if (O_s_wvalid & I_s_wready)
          wstate_nxt = (I_s_bvalid & O_s_bready) ? W_IDLE : W_RESP;
      end
      W_RESP: begin
        O_s_bready  = wgnt ? I_m1_bready : I_m0_bready;
        O_m0_bvalid = ~wgnt & I_s_bvalid;
        O_m1_bvalid = wgnt & I_s_bvalid;
        if (I_s_bvalid & O_s_bready) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_040750_clint_arb.sv
// tb/tb_ysyx_040750_clint_arb.sv - self-checking bench for ysyx_040750_clint_arb with a small CLINT model
module tb_ysyx_040750_clint_arb;
  localparam logic [31:0] A_MTIME = 32'h0200BFF8;
  localparam logic [31:0] A_CMP   = 32'h02004000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        arvalid [2], arready [2], rvalid [2], rready [2];
  logic        awvalid [2], awready [2], wvalid [2], wready [2], bvalid [2], bready [2];
  logic [31:0] araddr [2], awaddr [2];
  logic [63:0] rdata [2], wdata [2];
  logic [7:0]  wstrb [2];

  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic        s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_araddr, s_awaddr;
  logic [63:0] s_rdata, s_wdata;
  logic [7:0]  s_wstrb;
  logic        rd_busy, wr_busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_040750_clint_arb dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_m0_arvalid(arvalid[0]), .O_m0_arready(arready[0]), .I_m0_araddr(araddr[0]),
    .O_m0_rvalid(rvalid[0]), .I_m0_rready(rready[0]), .O_m0_rdata(rdata[0]),
    .I_m0_awvalid(awvalid[0]), .O_m0_awready(awready[0]), .I_m0_awaddr(awaddr[0]),
    .I_m0_wvalid(wvalid[0]), .O_m0_wready(wready[0]), .I_m0_wdata(wdata[0]), .I_m0_wstrb(wstrb[0]),
    .O_m0_bvalid(bvalid[0]), .I_m0_bready(bready[0]),
    .I_m1_arvalid(arvalid[1]), .O_m1_arready(arready[1]), .I_m1_araddr(araddr[1]),
    .O_m1_rvalid(rvalid[1]), .I_m1_rready(rready[1]), .O_m1_rdata(rdata[1]),
    .I_m1_awvalid(awvalid[1]), .O_m1_awready(awready[1]), .I_m1_awaddr(awaddr[1]),
    .I_m1_wvalid(wvalid[1]), .O_m1_wready(wready[1]), .I_m1_wdata(wdata[1]), .I_m1_wstrb(wstrb[1]),
    .O_m1_bvalid(bvalid[1]), .I_m1_bready(bready[1]),
    .O_s_arvalid(s_arvalid), .I_s_arready(s_arready), .O_s_araddr(s_araddr),
    .I_s_rvalid(s_rvalid), .O_s_rready(s_rready), .I_s_rdata(s_rdata),
    .O_s_awvalid(s_awvalid), .I_s_awready(s_awready), .O_s_awaddr(s_awaddr),
    .O_s_wvalid(s_wvalid), .I_s_wready(s_wready), .O_s_wdata(s_wdata), .O_s_wstrb(s_wstrb),
    .I_s_bvalid(s_bvalid), .O_s_bready(s_bready),
    .O_rd_busy(rd_busy), .O_wr_busy(wr_busy)
  );

  // CLINT stand-in: arready/awready tied high, registered rvalid, bvalid with the w handshake.
  logic [63:0] mtime, mtimecmp;
  logic [31:0] aw_lat;
  logic        bpend, wr_en_s, mtip;
  assign s_arready = 1'b1;
  assign s_awready = 1'b1;
  assign s_wready  = wr_en_s;
  assign s_bvalid  = (s_wvalid & s_wready) | bpend;
  assign mtip      = (mtime >= mtimecmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime    <= 64'd0;
      mtimecmp <= '1;
      s_rvalid <= 1'b0;
      s_rdata  <= 64'd0;
      aw_lat   <= 32'd0;
      bpend    <= 1'b0;
    end else begin
      mtime <= mtime + 64'd1;
      if (s_arvalid & s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= (s_araddr == A_MTIME) ? mtime : (s_araddr == A_CMP) ? mtimecmp : 64'd0;
      end else if (s_rvalid & s_rready) begin
        s_rvalid <= 1'b0;
      end
      if (s_awvalid & s_awready) aw_lat <= s_awaddr;
      if (s_wvalid & s_wready) begin
        for (int i = 0; i < 8; i++)
          if (s_wstrb[i] && aw_lat == A_CMP) mtimecmp[8*i +: 8] <= s_wdata[8*i +: 8];
        bpend <= ~s_bready;
      end else if (bpend & s_bready) begin
        bpend <= 1'b0;
      end
    end
  end

  logic any_out;
  assign any_out = |{arready[0], rvalid[0], rdata[0], awready[0], wready[0], bvalid[0],
                     arready[1], rvalid[1], rdata[1], awready[1], wready[1], bvalid[1],
                     s_arvalid, s_araddr, s_rready, s_awvalid, s_awaddr, s_wvalid, s_wdata,
                     s_wstrb, s_bready, rd_busy, wr_busy};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_read(input int m, input logic [31:0] addr, input int hold, input bit quiet,
                         output logic [63:0] data, output int t_req, output int t_ar,
                         output int t_rv, output int t_hs, output logic [63:0] mt);
    bit ar_hs, done, stable, other_quiet;
    int held;
    logic [63:0] first;
    ar_hs = 0; done = 0; stable = 1; other_quiet = 1; held = 0; first = '0;
    data = '0; mt = '0; t_ar = -1; t_rv = -1; t_hs = -1;
    @(negedge clk);
    arvalid[m] = 1'b1; araddr[m] = addr; rready[m] = (hold == 0); t_req = cyc;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (quiet && (arready[1-m] || rvalid[1-m] || rdata[1-m] != 0)) other_quiet = 0;
      if (arvalid[m] && arready[m]) begin
        ar_hs = 1; t_ar = cyc; mt = mtime;
      end
      if (rvalid[m]) begin
        if (t_rv < 0) begin
          t_rv = cyc; first = rdata[m];
        end else if (rdata[m] !== first) stable = 0;
        if (rready[m]) begin
          done = 1; t_hs = cyc; data = rdata[m];
        end else held++;
      end
      @(negedge clk);
      if (ar_hs) arvalid[m] = 1'b0;
      if (held >= hold) rready[m] = 1'b1;
      if (done) rready[m] = 1'b0;
    end
    chk("rd_done", done, 1);
    if (hold > 0) chk("rd_stable", stable, 1);
    if (quiet) chk("rd_other_quiet", other_quiet, 1);
  endtask

  task automatic do_write(input int m, input logic [31:0] addr, input logic [63:0] d,
                          input logic [7:0] s, input int bhold,
                          output int t_req, output int t_w, output int t_b);
    bit aw_hs, w_hs, done;
    int held;
    aw_hs = 0; w_hs = 0; done = 0; held = 0; t_w = -1; t_b = -1;
    @(negedge clk);
    awvalid[m] = 1'b1; awaddr[m] = addr; wvalid[m] = 1'b1; wdata[m] = d; wstrb[m] = s;
    bready[m] = (bhold == 0); t_req = cyc;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (awvalid[m] && awready[m]) aw_hs = 1;
      if (wvalid[m] && wready[m]) begin
        w_hs = 1; t_w = cyc;
      end
      if (bvalid[m]) begin
        if (bready[m]) begin
          done = 1; t_b = cyc;
        end else held++;
      end
      @(negedge clk);
      if (aw_hs) awvalid[m] = 1'b0;
      if (w_hs) wvalid[m] = 1'b0;
      if (held >= bhold) bready[m] = 1'b1;
      if (done) bready[m] = 1'b0;
    end
    chk("wr_done", done, 1);
  endtask

  typedef struct {
    int          m;
    bit          wr;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [7:0]  st;
    int          hold;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs [7];
  logic [63:0] d0, d1, mt0, mt1;
  int          q0, q1, a0, a1, v0, v1, h0, h1, tw, tb;

  initial begin
    for (int i = 0; i < 2; i++) begin
      arvalid[i] = 0; rready[i] = 0; awvalid[i] = 0; wvalid[i] = 0; bready[i] = 0;
      araddr[i] = 0; awaddr[i] = 0; wdata[i] = 0; wstrb[i] = 0;
    end
    wr_en_s = 1'b1;
    vecs[0] = '{1, 1'b1, A_CMP, 64'h100, 8'hFF, 0, 64'h0};
    vecs[1] = '{0, 1'b0, A_CMP, 64'h0, 8'h00, 0, 64'h100};
    vecs[2] = '{0, 1'b1, A_CMP, 64'hAB, 8'h01, 2, 64'h0};
    vecs[3] = '{1, 1'b0, A_CMP, 64'h0, 8'h00, 0, 64'h1AB};
    vecs[4] = '{1, 1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 1, 64'h0};
    vecs[5] = '{0, 1'b0, A_CMP, 64'h0, 8'h00, 3, 64'hFFFF_FFFF_0000_01AB};
    vecs[6] = '{0, 1'b1, A_CMP, 64'h100, 8'hFF, 0, 64'h0};

    // Requests held during reset must not leak to any output.
    arvalid[0] = 1'b1; awvalid[1] = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", any_out, 0);
    arvalid[0] = 1'b0; awvalid[1] = 1'b0;
    rst_n = 1'b1;

    do_read(0, A_MTIME, 0, 1, d0, q0, a0, v0, h0, mt0);
    chk("solo_ar_lat", a0 - q0, 1);
    chk("solo_rv_lat", v0 - q0, 2);
    chk("solo_mtime", d0, mt0);

    for (int k = 0; k < 2; k++) begin
      fork
        do_read(0, A_MTIME, 0, 0, d0, q0, a0, v0, h0, mt0);
        do_read(1, A_MTIME, 0, 0, d1, q1, a1, v1, h1, mt1);
      join
      chk("tie_m0_first", v0 - q0, 2);
      chk("tie_m1_after", v1 - v0, 3);
      chk("tie_m1_data", d1, mt1);
    end

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].m, vecs[i].addr, vecs[i].wd, vecs[i].st, vecs[i].hold, q0, tw, tb);
        chk("vec_w_lat", tw - q0, 2);
        chk("vec_b_lat", tb - tw, vecs[i].hold);
      end else begin
        do_read(vecs[i].m, vecs[i].addr, vecs[i].hold, 1, d0, q0, a0, v0, h0, mt0);
        chk("vec_rdata", d0, vecs[i].exp);
        chk("vec_hs", h0 - v0, vecs[i].hold);
      end
    end

    fork
      do_write(1, A_CMP, 64'h100, 8'hFF, 0, q1, tw, tb);
      do_read(0, A_MTIME, 0, 0, d0, q0, a0, v0, h0, mt0);
    join
    chk("conc_b_lat", tb - q1, 2);
    chk("conc_rv_lat", v0 - q0, 2);
    chk("conc_mtime", d0, mt0);
    chk("mtip_low", mtip, 0);
    for (int i = 0; i < 600 && !mtip; i++) @(negedge clk);
    chk("mtip_high", mtip, 1);

    fork
      do_read(0, A_CMP, 5, 0, d0, q0, a0, v0, h0, mt0);
      begin
        @(negedge clk);
        do_read(1, A_CMP, 0, 0, d1, q1, a1, v1, h1, mt1);
      end
    join
    chk("hold_hs", h0 - q0, 7);
    chk("hold_data", d0, 64'h100);
    chk("hold_m1_wait", v1 - h0, 3);

    // Stall the slave's wready to park the write FSM in W_DATA, then reset between edges.
    wr_en_s = 1'b0;
    @(negedge clk);
    awvalid[1] = 1'b1; awaddr[1] = A_CMP; wvalid[1] = 1'b1; wdata[1] = 64'h55; wstrb[1] = 8'hFF;
    bready[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    awvalid[1] = 1'b0;
    #1 chk("wdata_busy", {wr_busy, s_wvalid}, 2'b11);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", any_out, 0);
    @(negedge clk);
    wvalid[1] = 1'b0; bready[1] = 1'b0; wr_en_s = 1'b1;
    rst_n = 1'b1;
    do_write(1, A_CMP, 64'h200, 8'hFF, 0, q1, tw, tb);
    chk("post_rst_b", tb - q1, 2);
    do_read(0, A_CMP, 0, 1, d0, q0, a0, v0, h0, mt0);
    chk("post_rst_data", d0, 64'h200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
